// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller: scan FSM states
// and the all-dark drive levels for the active-low anode and segment buses.
package sseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex2sseg.sv
// Hex nibble to active-low seven-segment pattern, seg[0] = a ... seg[6] = g.
module hex2sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/priority_encoder_generic.sv
// Index of the highest set request bit; returns 0 when no bit is set.
module priority_encoder_generic #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  // Ascending scan so the highest set bit overwrites any lower one.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with a shadow/active
// register pair so that new values only take effect at frame boundaries.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS        = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  load_mask,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        lz_en,
  output logic [7:0]  AN,
  output logic [6:0]  F,
  output logic        DP,
  output logic        frame_start
);

  localparam int TICK_W  = $clog2(TICKS_PER_DIGIT);
  localparam int DIGIT_W = $clog2(N_DIGITS);
  localparam logic [TICK_W-1:0] LAST_BLANK = TICK_W'(BLANK_TICKS - 1);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(TICKS_PER_DIGIT - 1);

  scan_state_t        state, state_nxt;
  logic [TICK_W-1:0]  tick, tick_nxt;
  logic [DIGIT_W-1:0] digit, digit_nxt;

  logic [31:0] shadow_data, active_data;
  logic [7:0]  shadow_dp, active_dp;
  logic [7:0]  shadow_mask, active_lit;
  logic        pending;

  logic [N_DIGITS-1:0] nz_flags;
  logic [DIGIT_W-1:0]  lead_idx;
  logic [7:0]          lz_keep;
  logic [3:0]          nibble;
  logic [6:0]          seg_cur;
  logic [7:0]          an_d;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic                frame_edge;

  // The counters describe the slot position that the output registers load
  // on the next edge, so outputs line up with the position they represent.
  assign frame_edge = (state == ST_BLANK) && (digit == '0) && (tick == '0);
  assign nibble     = active_data[{digit, 2'b00} +: 4];

  hex2sseg u_hex2sseg (
    .hex (nibble),
    .seg (seg_cur)
  );

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      nz_flags[i] = |shadow_data[4*i +: 4];
    end
  end

  priority_encoder_generic #(.N(8)) u_lead_enc (
    .req (nz_flags),
    .idx (lead_idx)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lz_keep[i] = !lz_en || (DIGIT_W'(i) <= lead_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_BLANK;
      tick  <= '0;
      digit <= '0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
      digit <= digit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick + 1'b1;
    digit_nxt = digit;
    an_d      = AN_OFF;
    seg_d     = SEG_OFF;
    dp_d      = 1'b1;
    case (state)
      ST_BLANK: begin
        if (tick == LAST_BLANK) state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        // Dark digits keep their slot so the refresh rate stays constant.
        if (active_lit[digit]) begin
          an_d  = ~(8'h01 << digit);
          seg_d = seg_cur;
          dp_d  = ~active_dp[digit];
        end
        if (tick == LAST_TICK) begin
          state_nxt = ST_BLANK;
          tick_nxt  = '0;
          digit_nxt = digit + 1'b1;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  // Accept and commit are exclusive: accepting needs ready, committing needs pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_mask <= '0;
      active_data <= '0;
      active_dp   <= '0;
      active_lit  <= '0;
      pending     <= 1'b0;
      load_ready  <= 1'b0;
    end else if (load_valid && load_ready) begin
      shadow_data <= load_data;
      shadow_dp   <= load_dp;
      shadow_mask <= load_mask;
      pending     <= 1'b1;
      load_ready  <= 1'b0;
    end else if (frame_edge && pending) begin
      active_data <= shadow_data;
      active_dp   <= shadow_dp;
      active_lit  <= shadow_mask & lz_keep;
      pending     <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      load_ready  <= ~pending;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      AN          <= AN_OFF;
      F           <= SEG_OFF;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      AN          <= an_d;
      F           <= seg_d;
      DP          <= dp_d;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized self-checking bench for sseg_scan_ctrl; expectations come from a
// cycle-count model of the frame/slot schedule and the shadow/active banks.
module tb_sseg_scan_ctrl;

  localparam int TPD   = 8;
  localparam int BT    = 2;
  localparam int ND    = 8;
  localparam int FRAME = TPD * ND;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic [7:0]  load_mask;
  logic        load_valid;
  logic        load_ready;
  logic        lz_en;
  logic [7:0]  AN;
  logic [6:0]  F;
  logic        DP;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  int          n;
  bit          m_pending;
  bit          m_ready;
  bit          xfer_seen;
  int          last_xfer_pos;
  logic [31:0] sh_data, act_data;
  logic [7:0]  sh_dp, sh_mask, act_dp, act_lit;

  sseg_scan_ctrl #(
    .N_DIGITS        (ND),
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .load_mask   (load_mask),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .lz_en       (lz_en),
    .AN          (AN),
    .F           (F),
    .DP          (DP),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s at n=%0d: got %h expected %h", tag, n, obs, exp);
    end
  endtask

  // Model of what the design does at one rising edge, from the inputs held during the cycle.
  task automatic model_edge();
    int lead;
    xfer_seen = 0;
    if (!reset_n) begin
      n = -1;
      m_pending = 0;
      m_ready = 0;
      sh_data = '0; sh_dp = '0; sh_mask = '0;
      act_data = '0; act_dp = '0; act_lit = '0;
    end else begin
      if (n >= 0 && (n % FRAME) == FRAME - 1 && m_pending) begin
        lead = 0;
        for (int i = 0; i < ND; i++) if (sh_data[i*4 +: 4] != 4'h0) lead = i;
        act_data = sh_data;
        act_dp   = sh_dp;
        for (int i = 0; i < ND; i++) act_lit[i] = sh_mask[i] && (!lz_en || i <= lead);
        m_pending = 0;
      end
      if (load_valid && m_ready) begin
        sh_data = load_data;
        sh_dp   = load_dp;
        sh_mask = load_mask;
        m_pending = 1;
        xfer_seen = 1;
        last_xfer_pos = (n < 0) ? -1 : (n % FRAME);
      end
      n++;
      m_ready = !m_pending;
    end
  endtask

  task automatic step();
    int p, d, t;
    logic [7:0] e_an;
    logic [6:0] e_f;
    logic e_dp, e_fs, e_rdy;
    @(posedge clk);
    model_edge();
    #1;
    e_an = 8'hFF; e_f = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_rdy = 1'b0;
    if (n >= 0) begin
      p = n % FRAME;
      d = p / TPD;
      t = p % TPD;
      e_fs  = (p == 0);
      e_rdy = m_ready;
      if (t >= BT && act_lit[d]) begin
        e_an = ~(8'h01 << d);
        e_f  = seg_of(act_data[d*4 +: 4]);
        e_dp = ~act_dp[d];
      end
    end
    checkOutput("AN", 32'(AN), 32'(e_an));
    checkOutput("F", 32'(F), 32'(e_f));
    checkOutput("DP", 32'(DP), 32'(e_dp));
    checkOutput("frame_start", 32'(frame_start), 32'(e_fs));
    checkOutput("load_ready", 32'(load_ready), 32'(e_rdy));
  endtask

  // Idle cycles scramble the load bus so only handshaken values may be captured.
  task automatic run_cycles(input int cnt, input bit scramble_lz);
    for (int k = 0; k < cnt; k++) begin
      step();
      load_data = $urandom;
      load_dp   = 8'($urandom);
      load_mask = 8'($urandom);
      if (scramble_lz) lz_en = 1'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dp,
                               input logic [7:0] mask, input logic lz);
    bit acc;
    acc = 0;
    load_data  = data;
    load_dp    = dp;
    load_mask  = mask;
    lz_en      = lz;
    load_valid = 1'b1;
    for (int k = 0; k < 300 && !acc; k++) begin
      step();
      if (xfer_seen) acc = 1;
    end
    load_valid = 1'b0;
    checkOutput("load_accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    int guard;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    load_mask  = '0;
    lz_en      = 1'b0;
    n          = -1;
    last_xfer_pos = -1;

    repeat (3) step();
    reset_n = 1'b1;
    $display("[TB] reset released, scanning with empty display");
    run_cycles(140, 1'b0);

    applyStimulus(32'h89ABCDEF, 8'h01, 8'hFF, 1'b0);
    run_cycles(140, 1'b0);

    $display("[TB] back-to-back loads");
    applyStimulus(32'h12345678, 8'hF0, 8'hFF, 1'b0);
    applyStimulus(32'h9E3779B9, 8'h0F, 8'h7E, 1'b0);
    checkOutput("b2b_accept_pos", 32'(last_xfer_pos), 32'd0);
    run_cycles(140, 1'b0);

    $display("[TB] leading-zero blanking");
    applyStimulus(32'h00000420, 8'h00, 8'hFF, 1'b1);
    run_cycles(140, 1'b0);
    applyStimulus(32'h00000000, 8'hFF, 8'hFF, 1'b1);
    run_cycles(140, 1'b0);

    applyStimulus($urandom, 8'($urandom), 8'hA5, 1'b0);
    run_cycles(140, 1'b0);

    $display("[TB] randomized loads");
    for (int r = 0; r < 12; r++) begin
      run_cycles(int'($urandom_range(0, 80)), 1'b1);
      applyStimulus($urandom >> $urandom_range(0, 31), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    run_cycles(140, 1'b1);

    $display("[TB] reset during SHOW with a pending load");
    guard = 0;
    while ((n % FRAME) != 1 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    applyStimulus(32'hDEADBEEF, 8'hFF, 8'hFF, 1'b0);
    guard = 0;
    while ((n % TPD) < BT && guard < TPD) begin
      step();
      guard++;
    end
    checkOutput("pending_before_reset", 32'(m_pending), 32'd1);
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    run_cycles(140, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
